rpll_phase_ctrl: RTL and testbench

Sequencer and configuration controller for the Gowin rPLL on the HDMI clock path. It holds the PLL in reset after power-up, waits for lock, and retries on timeout. After lock it drives the dynamic phase (PSDA), duty (DUTYDA) and fine-delay (FDLY) inputs, walking phase one step at a time with a settle window per step so the serializer clock never jumps more than one phase step. It sits between the video-timing/config logic and the rPLL instance.

---
 rtl/rpll_phase_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rpll_phase_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpll_phase_ctrl.sv
// Gowin rPLL sequencer: reset/lock/retry handling plus a phase walker that moves
// PSDA one step per settle window so the serializer clock never jumps more than one step.
module rpll_phase_ctrl #(
    parameter int         RESET_CYCLES  = 16,
    parameter int         LOCK_TIMEOUT  = 65536,
    parameter int         SETTLE_CYCLES = 8,
    parameter int         MAX_RETRIES   = 3,
    parameter logic [3:0] PSDA_INIT     = 4'h0,
    parameter logic [3:0] DUTYDA_INIT   = 4'h8,
    parameter logic [3:0] FDLY_INIT     = 4'h0
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    output logic [3:0] pll_fdly,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    input  logic [3:0] cfg_fdly,
    output logic       clk_ok,
    output logic       lost_lock,
    output logic       lock_err,
    output logic [3:0] retry_cnt
);

    localparam int CNT_MAX_RS = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX    = (LOCK_TIMEOUT > CNT_MAX_RS) ? LOCK_TIMEOUT : CNT_MAX_RS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_SETTLE,
        ST_ERROR
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lock_meta;
    logic             r_lock_sync;
    logic [3:0]       r_target;
    logic             r_pll_reset;
    logic [3:0]       r_psda;
    logic [3:0]       r_dutyda;
    logic [3:0]       r_fdly;
    logic             r_cfg_ready;
    logic             r_clk_ok;
    logic             r_lost_lock;
    logic             r_lock_err;
    logic [3:0]       r_retry_cnt;

    logic             w_lock_s;
    logic [3:0]       w_diff;
    logic             w_step_up;
    logic [3:0]       w_psda_next;
    logic [3:0]       w_retry_inc;

    // pll_lock comes from the PLL's own domain; only the synchronized copy is used.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_sync <= r_lock_meta;
        end
    end

    assign w_lock_s    = r_lock_sync;
    // Modular distance picks the short way round; a distance of exactly 8 steps up.
    assign w_diff      = r_target - r_psda;
    assign w_step_up   = (w_diff != 4'd0) && (w_diff <= 4'd8);
    assign w_psda_next = w_step_up ? (r_psda + 4'd1) : (r_psda - 4'd1);
    assign w_retry_inc = r_retry_cnt + 4'd1;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RST_HOLD;
            r_cnt       <= '0;
            r_target    <= PSDA_INIT;
            r_pll_reset <= 1'b1;
            r_psda      <= PSDA_INIT;
            r_dutyda    <= DUTYDA_INIT;
            r_fdly      <= FDLY_INIT;
            r_cfg_ready <= 1'b0;
            r_clk_ok    <= 1'b0;
            r_lost_lock <= 1'b0;
            r_lock_err  <= 1'b0;
            r_retry_cnt <= 4'd0;
        end else begin
            unique case (r_state)
                ST_RST_HOLD: begin
                    if (r_cnt == RESET_LAST) begin
                        r_state     <= ST_WAIT_LOCK;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state     <= ST_LOCKED;
                        r_retry_cnt <= 4'd0;
                        r_cfg_ready <= 1'b1;
                        r_clk_ok    <= 1'b1;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_retry_cnt <= w_retry_inc;
                        r_cnt       <= '0;
                        r_pll_reset <= 1'b1;
                        if (w_retry_inc == RETRY_LIMIT) begin
                            r_state    <= ST_ERROR;
                            r_lock_err <= 1'b1;
                        end else begin
                            r_state <= ST_RST_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_LOCKED, ST_SETTLE: begin
                    // Lock loss outranks everything, including a pending phase step.
                    if (!w_lock_s) begin
                        r_state     <= ST_RST_HOLD;
                        r_cnt       <= '0;
                        r_target    <= r_psda;
                        r_pll_reset <= 1'b1;
                        r_cfg_ready <= 1'b0;
                        r_clk_ok    <= 1'b0;
                        r_lost_lock <= 1'b1;
                    end else if (r_state == ST_LOCKED) begin
                        if (cfg_valid && r_cfg_ready) begin
                            r_state     <= ST_SETTLE;
                            r_cnt       <= SETTLE_LAST;
                            r_target    <= cfg_psda;
                            r_dutyda    <= cfg_dutyda;
                            r_fdly      <= cfg_fdly;
                            r_cfg_ready <= 1'b0;
                            r_clk_ok    <= 1'b0;
                        end
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_psda == r_target) begin
                        r_state     <= ST_LOCKED;
                        r_cfg_ready <= 1'b1;
                        r_clk_ok    <= 1'b1;
                    end else begin
                        r_psda <= w_psda_next;
                        r_cnt  <= SETTLE_LAST;
                    end
                end
                ST_ERROR: begin
                    r_pll_reset <= 1'b1;
                    r_lock_err  <= 1'b1;
                end
                default: begin
                    r_state     <= ST_RST_HOLD;
                    r_cnt       <= '0;
                    r_pll_reset <= 1'b1;
                    r_cfg_ready <= 1'b0;
                    r_clk_ok    <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset  = r_pll_reset;
    assign pll_psda   = r_psda;
    assign pll_dutyda = r_dutyda;
    assign pll_fdly   = r_fdly;
    assign cfg_ready  = r_cfg_ready;
    assign clk_ok     = r_clk_ok;
    assign lost_lock  = r_lost_lock;
    assign lock_err   = r_lock_err;
    assign retry_cnt  = r_retry_cnt;

endmodule

// File: tb/tb_rpll_phase_ctrl.sv
// Self-checking bench for rpll_phase_ctrl: lock sequencing, retries, phase walks and
// lock loss, checked against an arithmetic model of the walk timeline.
module tb_rpll_phase_ctrl;

    localparam int RST_CYC = 16;
    localparam int TIMEOUT = 64;
    localparam int SETTLE  = 8;
    localparam int RETRIES = 3;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    logic [3:0] pll_psda, pll_dutyda, pll_fdly;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_psda = 4'h0, cfg_dutyda = 4'h0, cfg_fdly = 4'h0;
    logic       clk_ok, lost_lock, lock_err;
    logic [3:0] retry_cnt;

    int vectors = 0;
    int misses  = 0;
    int modelPsda, modelDuty, modelFdly;
    int walkFrom, walkTarget;

    rpll_phase_ctrl #(
        .RESET_CYCLES (RST_CYC),
        .LOCK_TIMEOUT (TIMEOUT),
        .SETTLE_CYCLES(SETTLE),
        .MAX_RETRIES  (RETRIES),
        .PSDA_INIT    (4'h0),
        .DUTYDA_INIT  (4'h8),
        .FDLY_INIT    (4'h0)
    ) dut (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .pll_reset (pll_reset),
        .pll_psda  (pll_psda),
        .pll_dutyda(pll_dutyda),
        .pll_fdly  (pll_fdly),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_psda  (cfg_psda),
        .cfg_dutyda(cfg_dutyda),
        .cfg_fdly  (cfg_fdly),
        .clk_ok    (clk_ok),
        .lost_lock (lost_lock),
        .lock_err  (lock_err),
        .retry_cnt (retry_cnt)
    );

    always #5 clkin = ~clkin;

    task automatic tick(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            misses++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        checkOutput({tag, "_psda"}, 32'(pll_psda), 32'h0);
        checkOutput({tag, "_dutyda"}, 32'(pll_dutyda), 32'h8);
        checkOutput({tag, "_fdly"}, 32'(pll_fdly), 32'h0);
        checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
        checkOutput({tag, "_clk_ok"}, 32'(clk_ok), 32'd0);
        checkOutput({tag, "_lost_lock"}, 32'(lost_lock), 32'd0);
        checkOutput({tag, "_lock_err"}, 32'(lock_err), 32'd0);
        checkOutput({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
    endtask

    // Cycles spent with pll_reset at the given level, bounded so a stuck DUT still ends.
    task automatic measureLevel(input string tag, input logic level, input int expected);
        int count = 0;
        while (pll_reset === level && count < 400) begin
            tick(1);
            count++;
        end
        checkOutput(tag, 32'(count), 32'(expected));
    endtask

    // Walk model: shortest modular route, ties at distance 8 go upward.
    function automatic int walkDist();
        return (walkTarget - walkFrom) & 15;
    endfunction

    function automatic int walkSteps();
        int d = walkDist();
        return (d <= 8) ? d : 16 - d;
    endfunction

    function automatic int walkDir();
        int d = walkDist();
        return (d >= 1 && d <= 8) ? 1 : -1;
    endfunction

    task automatic startConfig(input int target, input int duty, input int fdly);
        checkOutput("ready_before_cfg", 32'(cfg_ready), 32'd1);
        cfg_psda   = 4'(target);
        cfg_dutyda = 4'(duty);
        cfg_fdly   = 4'(fdly);
        cfg_valid  = 1'b1;
        tick(1);
        cfg_valid  = 1'b0;
        modelDuty  = duty;
        modelFdly  = fdly;
        walkFrom   = modelPsda;
        walkTarget = target;
        checkOutput("dutyda_on_accept", 32'(pll_dutyda), 32'(modelDuty));
        checkOutput("fdly_on_accept", 32'(pll_fdly), 32'(modelFdly));
        checkOutput("ready_low_on_accept", 32'(cfg_ready), 32'd0);
        checkOutput("clk_ok_low_on_accept", 32'(clk_ok), 32'd0);
    endtask

    // Checks each cycle of the walk; cycle numbers count from the accept edge.
    task automatic runWalk(input int firstCyc, input int lastCyc);
        int n = walkSteps();
        int s;
        for (int cyc = firstCyc; cyc <= lastCyc; cyc++) begin
            tick(1);
            s = cyc / SETTLE;
            if (s > n) s = n;
            modelPsda = (walkFrom + walkDir() * s) & 15;
            checkOutput("walk_psda", 32'(pll_psda), 32'(modelPsda));
            checkOutput("walk_ready", 32'(cfg_ready), 32'(cyc == SETTLE * (n + 1)));
        end
    endtask

    task automatic applyStimulus(input int target, input int duty, input int fdly);
        startConfig(target, duty, fdly);
        runWalk(1, SETTLE * (walkSteps() + 1));
        checkOutput("clk_ok_after_walk", 32'(clk_ok), 32'd1);
        checkOutput("psda_at_target", 32'(pll_psda), 32'(target));
    endtask

    initial begin
        int delay;
        int tgt;

        modelPsda = 0;
        modelDuty = 8;
        modelFdly = 0;

        #2 rst_n = 1'b0;
        tick(3);
        checkResetValues("reset");

        rst_n = 1'b1;
        measureLevel("reset_hold_len", 1'b1, RST_CYC);
        delay = $urandom_range(1, 40);
        tick(delay);
        pll_lock = 1'b1;
        tick(2);
        checkOutput("clk_ok_lock_plus2", 32'(clk_ok), 32'd0);
        tick(1);
        checkOutput("clk_ok_lock_plus3", 32'(clk_ok), 32'd1);
        checkOutput("ready_locked", 32'(cfg_ready), 32'd1);
        checkOutput("retry_locked", 32'(retry_cnt), 32'd0);
        checkOutput("pll_reset_locked", 32'(pll_reset), 32'd0);

        applyStimulus(2, 8, 0);
        applyStimulus(5, 3, 1);
        applyStimulus(1, 3, 1);
        applyStimulus(14, 3, 1);
        applyStimulus(14, 6, 2);

        for (int i = 0; i < 6; i++) begin
            tgt = $urandom_range(15);
            if (i == 0) begin
                startConfig(tgt, $urandom_range(15), $urandom_range(15));
                runWalk(1, 3);
                cfg_psda   = 4'($urandom_range(15));
                cfg_dutyda = ~4'(modelDuty);
                cfg_fdly   = ~4'(modelFdly);
                cfg_valid  = 1'b1;
                runWalk(4, 4);
                cfg_valid  = 1'b0;
                checkOutput("ignored_cfg_duty", 32'(pll_dutyda), 32'(modelDuty));
                checkOutput("ignored_cfg_fdly", 32'(pll_fdly), 32'(modelFdly));
                runWalk(5, SETTLE * (walkSteps() + 1));
            end else begin
                applyStimulus(tgt, $urandom_range(15), $urandom_range(15));
            end
        end

        // Lock drops so that the FSM sees it on the same edge the settle counter expires.
        applyStimulus(4, 7, 9);
        startConfig(9, 7, 9);
        runWalk(1, 21);
        pll_lock = 1'b0;
        runWalk(22, 23);
        tick(1);
        checkOutput("loss_pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("loss_lost_lock", 32'(lost_lock), 32'd1);
        checkOutput("loss_psda_held", 32'(pll_psda), 32'd6);
        checkOutput("loss_ready", 32'(cfg_ready), 32'd0);
        checkOutput("loss_clk_ok", 32'(clk_ok), 32'd0);
        measureLevel("loss_reset_len", 1'b1, RST_CYC);
        checkOutput("relock_psda_kept", 32'(pll_psda), 32'(modelPsda));
        checkOutput("relock_duty_kept", 32'(pll_dutyda), 32'(modelDuty));
        pll_lock = 1'b1;
        tick(3);
        checkOutput("relock_clk_ok", 32'(clk_ok), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(10);
            checkOutput("relock_no_step", 32'(pll_psda), 32'd6);
            checkOutput("relock_ready", 32'(cfg_ready), 32'd1);
            checkOutput("relock_lost_sticky", 32'(lost_lock), 32'd1);
        end

        startConfig((modelPsda + 3) & 15, 3, 5);
        runWalk(1, 10);
        rst_n = 1'b0;
        #1;
        checkResetValues("reset_mid_walk");
        modelPsda = 0;

        pll_lock = 1'b0;
        tick(3);
        rst_n = 1'b1;
        for (int r = 1; r <= RETRIES; r++) begin
            measureLevel("retry_hold_len", 1'b1, RST_CYC);
            measureLevel("retry_wait_len", 1'b0, TIMEOUT);
            checkOutput("retry_count", 32'(retry_cnt), 32'(r));
            checkOutput("retry_lock_err", 32'(lock_err), 32'(r == RETRIES));
        end
        tick(40);
        checkOutput("error_pll_reset", 32'(pll_reset), 32'd1);
        checkOutput("error_lock_err", 32'(lock_err), 32'd1);
        checkOutput("error_retry", 32'(retry_cnt), 32'd3);
        pll_lock = 1'b1;
        tick(10);
        checkOutput("error_sticky", 32'(lock_err), 32'd1);
        checkOutput("error_clk_ok", 32'(clk_ok), 32'd0);
        checkOutput("error_ready", 32'(cfg_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
